// File: rtl/load_unit.sv
// RV32 load unit: effective address, one word read over valid/ready, lane extract + extend, writeback.
// Optional build macro LOAD_MISALIGN_TRAP_EN faults misaligned LH/LHU/LW at acceptance without a memory access.
//   state  | meaning
//   S_IDLE | ready for a new load
//   S_ADDR | memory read request presented
//   S_WAIT | waiting for read response (timeout counter running)
//   S_WB   | result presented on writeback port
module load_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_imm,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_WB} state_e;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [31:0] ea_calc;
  logic [CW-1:0] cnt_inc;
  logic        illegal;
  logic        misal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign ea_calc = req_base + {{20{req_imm[11]}}, req_imm};
  assign cnt_inc = cnt_q + 1'b1;
  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misal = ((req_funct3[1:0] == 2'b01) && ea_calc[0]) ||
                 ((req_funct3 == 3'b010) && (ea_calc[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    byte_sel = mem_rsp_data[7:0];
    case (ea_q[1:0])
      2'd1:    byte_sel = mem_rsp_data[15:8];
      2'd2:    byte_sel = mem_rsp_data[23:16];
      2'd3:    byte_sel = mem_rsp_data[31:24];
      default: byte_sel = mem_rsp_data[7:0];
    endcase
    half_sel = ea_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    ext_data = 32'd0;
    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext_data = mem_rsp_data;
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ea_d          = ea_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    err_d         = err_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ea_d  = ea_calc;
          f3_d  = req_funct3;
          rd_d  = req_rd;
          cnt_d = '0;
          if (illegal || misal) begin
            data_d  = 32'd0;
            err_d   = 1'b1;
            state_d = S_WB;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a response in the timeout cycle wins over the error
        if (mem_rsp_valid) begin
          data_d  = ext_data;
          err_d   = 1'b0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TC)) begin
            data_d  = 32'd0;
            err_d   = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ea_q    <= 32'd0;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      cnt_q   <= '0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr = {ea_q[31:2], 2'b00};
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_err   = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: vector table of single loads plus stall, timeout and reset sequences.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_imm;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  load_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_base(req_base), .req_imm(req_imm), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [31:0] rsp;
    logic        exp_mem;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  logic [31:0] r_data, r_addr;
  logic        r_err;
  logic [4:0]  r_rd;
  int          r_wbcyc;
  bit          r_mem, r_stable, r_rrlow, r_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one load and play memory/register-file; rsp_delay<0 means never respond.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] base, input logic [11:0] imm,
                          input logic [4:0] rd, input logic [31:0] rsp, input int mstall,
                          input int wstall, input int rsp_delay);
    int cyc, ms, ws, wc;
    bit in_wait;
    r_mem = 0; r_stable = 1; r_rrlow = 1; r_wbcyc = -1; r_done = 0; r_addr = 0;
    r_data = 0; r_err = 0; r_rd = 0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_funct3 = f3; req_base = base; req_imm = imm; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 0;
    cyc = 1; ms = 0; ws = 0; wc = 0; in_wait = 0;
    while (!r_done && cyc < 60) begin
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 32'h5A5A_5A5A; wb_ready = 0;
      if (req_ready) r_rrlow = 0;
      if (wb_valid) begin
        in_wait = 0;
        if (r_wbcyc < 0) begin
          r_wbcyc = cyc; r_data = wb_data; r_err = wb_err; r_rd = wb_rd;
        end else if ({wb_data, wb_err, wb_rd} !== {r_data, r_err, r_rd}) r_stable = 0;
        if (ws < wstall) ws++;
        else begin wb_ready = 1; r_done = 1; end
      end else if (mem_req_valid) begin
        if (!r_mem) begin r_mem = 1; r_addr = mem_addr; end
        else if (mem_addr !== r_addr) r_stable = 0;
        if (ms < mstall) ms++;
        else begin mem_req_ready = 1; in_wait = 1; end
      end else if (in_wait) begin
        if (wc == rsp_delay) begin mem_rsp_valid = 1; mem_rsp_data = rsp; end
        wc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_req_ready = 0; mem_rsp_valid = 0; wb_ready = 0;
    chk("wb_handshake_seen", 32'(r_done), 32'd1);
    chk("req_ready_after_wb", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    rst_n = 0; req_valid = 0; req_funct3 = 0; req_base = 0; req_imm = 0; req_rd = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; wb_ready = 0;

    vecs[0]  = '{3'b000, 32'h0000_1000, 12'hFFF, 5'd5,  32'h8000_0000, 1, 32'h0000_0FFC, 32'hFFFF_FF80, 0, 3};
    vecs[1]  = '{3'b101, 32'h0000_2002, 12'h000, 5'd6,  32'hBEEF_1234, 1, 32'h0000_2000, 32'h0000_BEEF, 0, 3};
    vecs[2]  = '{3'b001, 32'h0000_2002, 12'h000, 5'd7,  32'hBEEF_1234, 1, 32'h0000_2000, 32'hFFFF_BEEF, 0, 3};
    vecs[3]  = '{3'b010, 32'h0000_0100, 12'h004, 5'd8,  32'hDEAD_BEEF, 1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 3};
    vecs[4]  = '{3'b100, 32'h0000_3000, 12'h002, 5'd9,  32'h12AB_5678, 1, 32'h0000_3000, 32'h0000_00AB, 0, 3};
    vecs[5]  = '{3'b000, 32'h0000_0010, 12'h7FD, 5'd10, 32'h0000_7F00, 1, 32'h0000_080C, 32'h0000_007F, 0, 3};
    vecs[6]  = '{3'b001, 32'h0000_0000, 12'h800, 5'd11, 32'h0000_8001, 1, 32'hFFFF_F800, 32'hFFFF_8001, 0, 3};
    vecs[7]  = '{3'b011, 32'h0000_0400, 12'h000, 5'd12, 32'h1111_1111, 0, 32'h0,         32'h0,         1, 1};
    vecs[8]  = '{3'b111, 32'h0000_0400, 12'h000, 5'd13, 32'h1111_1111, 0, 32'h0,         32'h0,         1, 1};
`ifdef LOAD_MISALIGN_TRAP_EN
    vecs[9]  = '{3'b010, 32'h0000_3000, 12'h002, 5'd14, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         1, 1};
    vecs[10] = '{3'b101, 32'h0000_2003, 12'h000, 5'd15, 32'h8765_4321, 0, 32'h0,         32'h0,         1, 1};
`else
    vecs[9]  = '{3'b010, 32'h0000_3000, 12'h002, 5'd14, 32'hCAFE_F00D, 1, 32'h0000_3000, 32'hCAFE_F00D, 0, 3};
    vecs[10] = '{3'b101, 32'h0000_2003, 12'h000, 5'd15, 32'h8765_4321, 1, 32'h0000_2000, 32'h0000_8765, 0, 3};
`endif

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_load(vecs[i].f3, vecs[i].base, vecs[i].imm, vecs[i].rd, vecs[i].rsp, 0, 0, 0);
      chk($sformatf("v%0d_wb_data", i), r_data, vecs[i].exp_data);
      chk($sformatf("v%0d_wb_err", i), 32'(r_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_wb_rd", i), 32'(r_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_mem_issued", i), 32'(r_mem), 32'(vecs[i].exp_mem));
      if (vecs[i].exp_mem) chk($sformatf("v%0d_mem_addr", i), r_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_latency", i), 32'(r_wbcyc), 32'(vecs[i].exp_lat));
    end

    // memory and writeback backpressure
    run_load(3'b010, 32'h0000_4000, 12'h010, 5'd3, 32'hDEAD_BEEF, 4, 2, 0);
    chk("stall_wb_data", r_data, 32'hDEAD_BEEF);
    chk("stall_mem_addr", r_addr, 32'h0000_4010);
    chk("stall_stable", 32'(r_stable), 32'd1);
    chk("stall_req_ready_low", 32'(r_rrlow), 32'd1);
    chk("stall_latency", 32'(r_wbcyc), 32'd7);

    // no response: error 8 cycles after entering WAIT (WAIT starts at cycle 2)
    run_load(3'b010, 32'h0000_6000, 12'h000, 5'd4, 32'h0, 0, 0, -1);
    chk("timeout_err", 32'(r_err), 32'd1);
    chk("timeout_data", r_data, 32'd0);
    chk("timeout_latency", 32'(r_wbcyc), 32'd10);

    // response in the same cycle the timeout would fire
    run_load(3'b010, 32'h0000_6000, 12'h000, 5'd4, 32'h0BAD_F00D, 0, 0, 7);
    chk("edge_rsp_err", 32'(r_err), 32'd0);
    chk("edge_rsp_data", r_data, 32'h0BAD_F00D);
    chk("edge_rsp_latency", 32'(r_wbcyc), 32'd10);

    run_load(3'b100, 32'h0000_6001, 12'h000, 5'd2, 32'h0000_C300, 0, 0, 3);
    chk("late_rsp_data", r_data, 32'h0000_00C3);
    chk("late_rsp_latency", 32'(r_wbcyc), 32'd6);

    // reset while in WAIT, then a stale response
    req_valid = 1; req_funct3 = 3'b010; req_base = 32'h0000_5000; req_imm = 0; req_rd = 5'd7;
    @(posedge clk); #1;
    req_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_wb", {wb_valid, wb_err, wb_rd, 25'd0}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_1111;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 0;
      if (wb_valid || !req_ready) seen = 1;
    end
    chk("midrst_no_wb", 32'(seen), 32'd0);
    run_load(3'b010, 32'h0000_5000, 12'h008, 5'd9, 32'h7654_3210, 0, 0, 0);
    chk("post_rst_data", r_data, 32'h7654_3210);
    chk("post_rst_addr", r_addr, 32'h0000_5008);
    chk("post_rst_err", 32'(r_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
